// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: state encoding and default DATA_WIDTH / LATCH_CYCLES shared by the scanner and serializer
package ws2812b_pkg;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, PRESENT, LATCH} state_t;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_LATCH_CYCLES = 6000;
endpackage

// File: rtl/ws2812b_frame_scanner_if.sv
// ws2812b_frame_scanner_if: BRAM read port (bram_addr_out/bram_data_out) plus pixel valid/ready stream (pix_data/pix_valid/pix_ready/pix_last); master = scanner
interface ws2812b_frame_scanner_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] bram_addr_out;
  logic [DATA_WIDTH-1:0] bram_data_out;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_last;
  modport master (output bram_addr_out, pix_data, pix_valid, pix_last, input bram_data_out, pix_ready);
  modport slave (input bram_addr_out, pix_data, pix_valid, pix_last, output bram_data_out, pix_ready);
endinterface

// File: rtl/ws2812b_gap_timer.sv
// ws2812b_gap_timer: loadable down-counter (clk, reset, load/load_val in; done out, high while the count is 1)
module ws2812b_gap_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - WIDTH'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == WIDTH'(1);
endmodule

// File: rtl/ws2812b_frame_scanner.sv
// ws2812b_frame_scanner: walks the frame-buffer BRAM and streams pixels over bus (master), then a latch gap; clk, reset, enable in; busy, frame_done out
module ws2812b_frame_scanner
  import ws2812b_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_LEDS     = 64,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  ws2812b_frame_scanner_if.master bus,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int GW = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_LEDS - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                  pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
  logic                  gap_load, gap_done;
  ws2812b_gap_timer #(.WIDTH(GW)) u_gap (
    .clk,
    .reset,
    .load(gap_load),
    .load_val(GW'(LATCH_CYCLES)),
    .done(gap_done)
  );
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    gap_load    = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d  = '0;
        state_d = enable ? READ : IDLE;
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        pix_data_d  = bus.bram_data_out;
        pix_valid_d = 1'b1;
        pix_last_d  = addr_q == LAST_ADDR;
        state_d     = PRESENT;
      end
      PRESENT:
        if (bus.pix_ready) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          addr_d      = pix_last_q ? '0 : addr_q + ADDR_WIDTH'(1);
          gap_load    = pix_last_q;
          state_d     = pix_last_q ? LATCH : READ;
        end
      LATCH: state_d = !gap_done ? LATCH : enable ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  assign bus.bram_addr_out = addr_q;
  assign bus.pix_data      = pix_data_q;
  assign bus.pix_valid     = pix_valid_q;
  assign bus.pix_last      = pix_last_q;
  assign busy              = state_q != IDLE;
  assign frame_done        = state_q == LATCH && gap_done;
endmodule

// File: tb/tb_ws2812b_frame_scanner.sv
// tb_ws2812b_frame_scanner: randomized scenarios against a timing/ordering reference model for a 4-LED and a 256-LED scanner
module tb_ws2812b_frame_scanner;
  localparam int LA = 20;
  localparam int LB = 10;
  logic clk = 0, reset = 1, en_a = 0, en_b = 0, rdy_a = 0, rdy_b = 0;
  logic busy_a, done_a, busy_b, done_b;
  int checks = 0, errors = 0, cyc = 0;
  logic [23:0] mem_a [256];
  logic [23:0] mem_b [256];
  int hs_a[$], ha_a[$], vr_a[$], dn_a[$], hs_b[$], ha_b[$], vr_b[$], dn_b[$];
  logic [23:0] hd_a[$], hd_b[$];
  bit hl_a[$], hl_b[$];
  bit pv_a = 0, pv_b = 0;
  ws2812b_frame_scanner_if #(.DATA_WIDTH(24), .ADDR_WIDTH(8)) bus_a ();
  ws2812b_frame_scanner_if #(.DATA_WIDTH(24), .ADDR_WIDTH(8)) bus_b ();
  assign bus_a.pix_ready = rdy_a;
  assign bus_b.pix_ready = rdy_b;
  always @(posedge clk) bus_a.bram_data_out <= mem_a[bus_a.bram_addr_out];
  always @(posedge clk) bus_b.bram_data_out <= mem_b[bus_b.bram_addr_out];
  ws2812b_frame_scanner #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .NUM_LEDS(4), .LATCH_CYCLES(LA)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .bus(bus_a.master), .busy(busy_a), .frame_done(done_a));
  ws2812b_frame_scanner #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .NUM_LEDS(256), .LATCH_CYCLES(LB)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .bus(bus_b.master), .busy(busy_b), .frame_done(done_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Event recorder: cycle index of each accepted pixel, valid rise and frame_done
  always @(negedge clk) begin
    if (bus_a.pix_valid && rdy_a) begin
      hs_a.push_back(cyc); hd_a.push_back(bus_a.pix_data); hl_a.push_back(bus_a.pix_last); ha_a.push_back(int'(bus_a.bram_addr_out));
    end
    if (bus_a.pix_valid && !pv_a) vr_a.push_back(cyc);
    if (done_a) dn_a.push_back(cyc);
    pv_a = bus_a.pix_valid;
    if (bus_b.pix_valid && rdy_b) begin
      hs_b.push_back(cyc); hd_b.push_back(bus_b.pix_data); hl_b.push_back(bus_b.pix_last); ha_b.push_back(int'(bus_b.bram_addr_out));
    end
    if (bus_b.pix_valid && !pv_b) vr_b.push_back(cyc);
    if (done_b) dn_b.push_back(cyc);
    pv_b = bus_b.pix_valid;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_a();
    hs_a.delete(); ha_a.delete(); vr_a.delete(); dn_a.delete(); hd_a.delete(); hl_a.delete();
  endtask
  task automatic clear_b();
    hs_b.delete(); ha_b.delete(); vr_b.delete(); dn_b.delete(); hd_b.delete(); hl_b.delete();
  endtask
  task automatic wait_ev(input bit b, input int nv, input int nh, input int nd, input int max, output bit ok);
    ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      ok = b ? (vr_b.size() >= nv && hs_b.size() >= nh && dn_b.size() >= nd)
             : (vr_a.size() >= nv && hs_a.size() >= nh && dn_a.size() >= nd);
      if (!ok) tick();
    end
  endtask
  task automatic test_reset();
    repeat (2) tick();
    checks++; if (bus_a.bram_addr_out !== 8'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", bus_a.bram_addr_out); end
    checks++; if (bus_a.pix_data !== 24'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", bus_a.pix_data); end
    checks++; if ({bus_a.pix_valid, bus_a.pix_last, busy_a, done_a} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus_a.pix_valid, bus_a.pix_last, busy_a, done_a}); end
    checks++; if ({bus_b.pix_valid, busy_b, done_b} !== 3'b0) begin errors++; $display("FAIL reset_flags_b got %b exp 000", {bus_b.pix_valid, busy_b, done_b}); end
    reset = 0;
    repeat (3) tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_no_enable busy got %b exp 0", busy_a); end
  endtask
  task automatic test_frame_order();
    int c0;
    bit ok;
    for (int i = 0; i < 4; i++) mem_a[i] = 24'(i);
    clear_a(); rdy_a = 1; c0 = cyc; en_a = 1;
    wait_ev(0, 1, 0, 0, 50, ok);
    en_a = 0;
    wait_ev(0, 0, 0, 1, 300, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL order_timeout got 0 exp 1"); end
    checks++; if (hs_a.size() !== 4) begin errors++; $display("FAIL order_count got %0d exp 4", hs_a.size()); end
    for (int i = 0; i < hs_a.size(); i++) begin
      checks++; if (hd_a[i] !== 24'(i) || hl_a[i] !== (i == 3) || ha_a[i] !== i) begin errors++; $display("FAIL order_pix%0d got %0h/%b/%0d exp %0h/%b/%0d", i, hd_a[i], hl_a[i], ha_a[i], i, i == 3, i); end
    end
    checks++; if (vr_a.size() < 1 || vr_a[0] !== c0 + 3) begin errors++; $display("FAIL order_first_valid got %0d exp %0d", vr_a.size() ? vr_a[0] : -1, c0 + 3); end
    for (int i = 1; i < vr_a.size() && i < hs_a.size() + 1 && i < 4; i++) begin
      checks++; if (vr_a[i] !== hs_a[i-1] + 3) begin errors++; $display("FAIL order_period%0d got %0d exp %0d", i, vr_a[i], hs_a[i-1] + 3); end
    end
    checks++; if (dn_a.size() !== 1 || hs_a.size() < 4 || dn_a[0] !== hs_a[3] + LA) begin errors++; $display("FAIL order_done got %0d exp %0d", dn_a.size() ? dn_a[0] : -1, hs_a.size() >= 4 ? hs_a[3] + LA : -1); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL order_idle busy got %b exp 0", busy_a); end
  endtask
  task automatic test_stall();
    logic [23:0] d0;
    logic [7:0] a0;
    logic l0;
    bit ok;
    for (int i = 0; i < 4; i++) mem_a[i] = 24'($urandom);
    clear_a(); rdy_a = 0; en_a = 1;
    wait_ev(0, 1, 0, 0, 50, ok);
    en_a = 0;
    d0 = bus_a.pix_data; l0 = bus_a.pix_last; a0 = bus_a.bram_addr_out;
    checks++; if (d0 !== mem_a[0] || a0 !== 8'd0) begin errors++; $display("FAIL stall_first got %0h@%0d exp %0h@0", d0, a0, mem_a[0]); end
    repeat (10) begin
      tick();
      checks++; if (bus_a.pix_data !== d0 || bus_a.pix_last !== l0 || bus_a.bram_addr_out !== a0 || bus_a.pix_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold got %0h/%b/%0d exp %0h/%b/%0d", bus_a.pix_data, bus_a.pix_last, bus_a.bram_addr_out, d0, l0, a0); end
    end
    for (int k = 0; k < 600 && dn_a.size() == 0; k++) begin
      rdy_a = 1'($urandom_range(0, 1));
      tick();
    end
    rdy_a = 1;
    repeat (3) tick();
    checks++; if (hs_a.size() !== 4) begin errors++; $display("FAIL stall_count got %0d exp 4", hs_a.size()); end
    for (int i = 0; i < hs_a.size() && i < 4; i++) begin
      checks++; if (hd_a[i] !== mem_a[i] || hl_a[i] !== (i == 3) || ha_a[i] !== i) begin errors++; $display("FAIL stall_pix%0d got %0h/%b exp %0h/%b", i, hd_a[i], hl_a[i], mem_a[i], i == 3); end
      if (i > 0 && i < vr_a.size()) begin
        checks++; if (vr_a[i] !== hs_a[i-1] + 3 || hs_a[i] < vr_a[i]) begin errors++; $display("FAIL stall_timing%0d got %0d exp %0d", i, vr_a[i], hs_a[i-1] + 3); end
      end
    end
    checks++; if (dn_a.size() !== 1 || hs_a.size() < 4 || dn_a[0] !== hs_a[3] + LA) begin errors++; $display("FAIL stall_done got %0d exp %0d", dn_a.size() ? dn_a[0] : -1, hs_a.size() >= 4 ? hs_a[3] + LA : -1); end
  endtask
  task automatic test_enable_drop();
    bit ok;
    for (int i = 0; i < 4; i++) mem_a[i] = 24'($urandom);
    clear_a(); rdy_a = 1; en_a = 1;
    wait_ev(0, 0, 1, 0, 50, ok);
    en_a = 0;
    wait_ev(0, 0, 0, 1, 300, ok);
    repeat (20) tick();
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got 0 exp 1"); end
    checks++; if (hs_a.size() !== 4 || vr_a.size() !== 4) begin errors++; $display("FAIL drop_count got %0d/%0d exp 4/4", hs_a.size(), vr_a.size()); end
    for (int i = 0; i < hs_a.size() && i < 4; i++) begin
      checks++; if (hd_a[i] !== mem_a[i] || hl_a[i] !== (i == 3)) begin errors++; $display("FAIL drop_pix%0d got %0h/%b exp %0h/%b", i, hd_a[i], hl_a[i], mem_a[i], i == 3); end
    end
    checks++; if (dn_a.size() !== 1 || hs_a.size() < 4 || dn_a[0] !== hs_a[3] + LA) begin errors++; $display("FAIL drop_done got %0d exp %0d", dn_a.size() ? dn_a[0] : -1, hs_a.size() >= 4 ? hs_a[3] + LA : -1); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL drop_idle busy got %b exp 0", busy_a); end
  endtask
  task automatic test_continuous();
    bit ok;
    for (int i = 0; i < 4; i++) mem_a[i] = 24'($urandom);
    clear_a(); rdy_a = 1; en_a = 1;
    wait_ev(0, 0, 0, 2, 400, ok);
    en_a = 0;
    wait_ev(0, 0, 0, 3, 400, ok);
    repeat (10) tick();
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout got 0 exp 1"); end
    checks++; if (hs_a.size() !== 12 || dn_a.size() !== 3) begin errors++; $display("FAIL cont_count got %0d/%0d exp 12/3", hs_a.size(), dn_a.size()); end
    for (int i = 0; i < hs_a.size() && i < 12; i++) begin
      checks++; if (hd_a[i] !== mem_a[i % 4] || hl_a[i] !== (i % 4 == 3) || ha_a[i] !== i % 4) begin errors++; $display("FAIL cont_pix%0d got %0h/%b/%0d exp %0h/%b/%0d", i, hd_a[i], hl_a[i], ha_a[i], mem_a[i % 4], i % 4 == 3, i % 4); end
    end
    for (int k = 0; k < 3 && k < dn_a.size() && 4 * k + 3 < hs_a.size(); k++) begin
      checks++; if (dn_a[k] !== hs_a[4*k+3] + LA) begin errors++; $display("FAIL cont_done%0d got %0d exp %0d", k, dn_a[k], hs_a[4*k+3] + LA); end
      if (k < 2 && 4 * k + 4 < vr_a.size()) begin
        checks++; if (vr_a[4*k+4] !== dn_a[k] + 3) begin errors++; $display("FAIL cont_restart%0d got %0d exp %0d", k, vr_a[4*k+4], dn_a[k] + 3); end
      end
    end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cont_idle busy got %b exp 0", busy_a); end
  endtask
  task automatic test_full_range();
    bit ok;
    int bad = 0;
    for (int i = 0; i < 256; i++) mem_b[i] = 24'($urandom);
    clear_b(); rdy_b = 1; en_b = 1;
    wait_ev(1, 0, 0, 1, 2000, ok);
    en_b = 0;
    wait_ev(1, 0, 0, 2, 2000, ok);
    repeat (5) tick();
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout got 0 exp 1"); end
    checks++; if (hs_b.size() !== 512) begin errors++; $display("FAIL full_count got %0d exp 512", hs_b.size()); end
    for (int i = 0; i < hs_b.size() && i < 512; i++) begin
      checks++;
      if (hd_b[i] !== mem_b[i % 256] || ha_b[i] !== i % 256 || hl_b[i] !== (i % 256 == 255)) begin
        errors++;
        if (bad++ < 5) $display("FAIL full_pix%0d got %0h/%0d/%b exp %0h/%0d/%b", i, hd_b[i], ha_b[i], hl_b[i], mem_b[i % 256], i % 256, i % 256 == 255);
      end
    end
    checks++; if (dn_b.size() !== 2 || hs_b.size() < 256 || dn_b[0] !== hs_b[255] + LB) begin errors++; $display("FAIL full_done got %0d exp %0d", dn_b.size() ? dn_b[0] : -1, hs_b.size() >= 256 ? hs_b[255] + LB : -1); end
    checks++; if (vr_b.size() < 257 || dn_b.size() < 1 || vr_b[256] !== dn_b[0] + 3) begin errors++; $display("FAIL full_restart got %0d exp %0d", vr_b.size() > 256 ? vr_b[256] : -1, dn_b.size() ? dn_b[0] + 3 : -1); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL full_idle busy got %b exp 0", busy_b); end
  endtask
  task automatic test_reset_mid();
    int c0;
    bit ok;
    for (int i = 0; i < 4; i++) mem_a[i] = 24'($urandom);
    clear_a(); rdy_a = 0; en_a = 1;
    wait_ev(0, 1, 0, 0, 50, ok);
    tick();
    #2 reset = 1;
    #1;
    checks++; if ({bus_a.bram_addr_out, bus_a.pix_data, bus_a.pix_valid, bus_a.pix_last, busy_a, done_a} !== 36'd0) begin errors++; $display("FAIL rst_present got %0h/%0h/%b/%b/%b exp 0", bus_a.bram_addr_out, bus_a.pix_data, bus_a.pix_valid, bus_a.pix_last, busy_a); end
    tick();
    clear_a(); rdy_a = 1; c0 = cyc; reset = 0;
    wait_ev(0, 0, 4, 0, 100, ok);
    checks++; if (!ok || vr_a[0] !== c0 + 3 || hd_a[0] !== mem_a[0] || ha_a[0] !== 0) begin errors++; $display("FAIL rst_present_restart got %0d/%0h exp %0d/%0h", vr_a.size() ? vr_a[0] : -1, hd_a.size() ? hd_a[0] : 0, c0 + 3, mem_a[0]); end
    repeat (5) tick();
    #2 reset = 1;
    #1;
    checks++; if ({bus_a.bram_addr_out, bus_a.pix_data, bus_a.pix_valid, bus_a.pix_last, busy_a, done_a} !== 36'd0) begin errors++; $display("FAIL rst_latch got %0h/%0h/%b/%b/%b exp 0", bus_a.bram_addr_out, bus_a.pix_data, bus_a.pix_valid, bus_a.pix_last, busy_a); end
    tick();
    clear_a(); c0 = cyc; reset = 0;
    wait_ev(0, 1, 0, 0, 50, ok);
    en_a = 0;
    wait_ev(0, 0, 0, 1, 300, ok);
    repeat (3) tick();
    checks++; if (!ok || vr_a[0] !== c0 + 3 || hd_a[0] !== mem_a[0] || ha_a[0] !== 0) begin errors++; $display("FAIL rst_latch_restart got %0d/%0h exp %0d/%0h", vr_a.size() ? vr_a[0] : -1, hd_a.size() ? hd_a[0] : 0, c0 + 3, mem_a[0]); end
    checks++; if (hs_a.size() !== 4 || dn_a.size() !== 1 || dn_a[0] !== hs_a[3] + LA) begin errors++; $display("FAIL rst_latch_done got %0d exp %0d", dn_a.size() ? dn_a[0] : -1, hs_a.size() >= 4 ? hs_a[3] + LA : -1); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_idle busy got %b exp 0", busy_a); end
  endtask
  initial begin
    test_reset();
    test_frame_order();
    test_stall();
    test_enable_drop();
    test_continuous();
    test_full_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws2812b_frame_scanner.md
# ws2812b_frame_scanner

Sequences the read port of the display frame-buffer BRAM and streams one pixel word at a time to the WS2812B bit serializer over a valid/ready handshake. After the last LED of a frame it holds the line idle for the WS2812B latch/reset gap, pulses `frame_done`, and restarts if refresh is still enabled. It sits between the frame-buffer BRAM (read side only; the write side stays with the host) and the serializer.

## Interface
- `DATA_WIDTH`, 24: pixel word width (GRB, MSB first to serializer).
- `ADDR_WIDTH`, 8: BRAM address width.
- `NUM_LEDS`, 64: LEDs per frame; legal range 1 .. 2**ADDR_WIDTH.
- `LATCH_CYCLES`, 6000: clk cycles of latch gap after each frame; must be ≥1.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level; continuous frame refresh while high.
- `bram_addr_out` out ADDR_WIDTH: BRAM read address, registered.
- `bram_data_out` in DATA_WIDTH: BRAM read data, valid the cycle after the address is presented.
- `pix_data` out DATA_WIDTH: pixel to serializer.
- `pix_valid` out 1: `pix_data` valid.
- `pix_ready` in 1: serializer accepts on `pix_valid && pix_ready`.
- `pix_last` out 1: qualifies the current pixel as the last of the frame.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch gap.

## Operation
- States: IDLE, READ, CAPTURE, PRESENT, LATCH.
- IDLE: `busy`=0, address counter=0. On `enable`=1, go to READ.
- READ (1 cycle): `bram_addr_out` = address counter; BRAM samples it at the end of the cycle. Go to CAPTURE.
- CAPTURE (1 cycle): register `bram_data_out` into `pix_data`. Set `pix_valid`=1 and `pix_last` = (address == NUM_LEDS-1). Go to PRESENT.
- PRESENT:
  - Hold `pix_data`, `pix_valid` and `pix_last` stable until handshake.
  - On handshake with `pix_last`=0: increment address, go to READ.
  - On handshake with `pix_last`=1: clear address to 0, load gap counter, go to LATCH.
  - `pix_valid` drops in the cycle after the handshake.
- LATCH:
  - Count LATCH_CYCLES cycles, then pulse `frame_done` in the final LATCH cycle.
  - Next state: READ if `enable`=1 in that cycle, else IDLE.
- `enable` falling mid-frame never truncates a frame: the current frame and its latch gap complete, then the block goes to IDLE.
- `enable` is ignored outside IDLE and the final LATCH cycle.
- The last-pixel test compares against NUM_LEDS-1, never against counter overflow, so NUM_LEDS = 2**ADDR_WIDTH is legal.
- The gap counter is $clog2(LATCH_CYCLES+1) bits wide and counts down to 1.

## Timing
- Reset values: `bram_addr_out`=0, `pix_data`=0, `pix_valid`=0, `pix_last`=0, `busy`=0, `frame_done`=0, state=IDLE.
- Reset asserted mid-frame aborts immediately; the next frame after release starts at address 0.
- `enable` high at edge E0 gives: READ in cycle E0+1, CAPTURE in E0+2, `pix_valid`=1 from E0+3.
- From a handshake edge to the next `pix_valid`: 3 cycles (READ, CAPTURE, then valid). Minimum pixel period is 3 cycles.
- From the last-pixel handshake to `frame_done`: LATCH_CYCLES cycles.
- From `frame_done` to the next `pix_valid` with `enable` held: 3 cycles.

## Structure
- Package `ws2812b_pkg`: state encoding constants and the default DATA_WIDTH / LATCH_CYCLES values shared with the serializer.
- Sub-module `ws2812b_gap_timer`: loadable down-counter with a done strobe. It is reused by the serializer for its bit timing.

## Test plan
- NUM_LEDS=4, BRAM preloaded 0x000000..0x000003, `pix_ready` tied 1, `enable` pulse held → pixels 0,1,2,3 in order, each 3 cycles apart; `pix_last` only with 0x000003; `frame_done` LATCH_CYCLES cycles after the last handshake.
- `pix_ready` low for 10 cycles while valid → `pix_data` and `pix_last` stable throughout; no address advance.
- `enable` dropped during pixel 1 → pixels 2 and 3, then the latch gap and `frame_done` are still produced; then IDLE with `busy`=0.
- `enable` held continuously for 3 frames → addresses wrap 3→0; `pix_valid` 3 cycles after each `frame_done`.
- NUM_LEDS=256, ADDR_WIDTH=8 → all 256 addresses read; `pix_last` at address 255; next frame starts at address 0.
- `reset` asserted during PRESENT and during LATCH → all outputs 0 immediately; after release with `enable`=1, the frame restarts at address 0.
